// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM port arbiter.
package sram_arb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/sram_arb_pick.sv
// Winner selection: fixed priority with a starvation cap, or strict round robin
// when SRAM_ARB_RR_EN is defined. Holds the last-grant pointer and burst count.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_r0_req,
    input  logic i_r1_req,
    input  logic i_arb,
    output logic o_win_id,
    output logic o_gnt_vld
);
    logic r_last;
    logic w_win;

    assign o_gnt_vld = i_arb && (i_r0_req || i_r1_req);
    assign o_win_id  = w_win;

`ifdef SRAM_ARB_RR_EN
    always_comb begin
        w_win = REQ0;
        if (i_r0_req && i_r1_req)
            w_win = (r_last == REQ0) ? REQ1 : REQ0;
        else if (i_r1_req)
            w_win = REQ1;
    end
`else
    logic [3:0] r_burst;

    // r0 wins ties unless it has already used up its burst allowance.
    always_comb begin
        w_win = REQ0;
        if (i_r0_req && i_r1_req)
            w_win = (r_last == REQ0 && r_burst == 4'(MAX_BURST)) ? REQ1 : REQ0;
        else if (i_r1_req)
            w_win = REQ1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_burst <= 4'd0;
        else if (o_gnt_vld) begin
            if (w_win != r_last)
                r_burst <= 4'd1;
            else if (r_burst != 4'(MAX_BURST))
                r_burst <= r_burst + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= REQ1;
        else if (o_gnt_vld)
            r_last <= w_win;
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// Serialises two requesters onto one single-port SRAM with registered pins.
// Define SRAM_ARB_RR_EN for strict round-robin arbitration.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              csb_n,
    output logic              we_n,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] sram_data_in,
    input  logic [DATA_W-1:0] sram_data_out
);
    state_t            r_state, w_nxt;
    logic              r_we, r_id;
    logic              r_csb_n, r_we_n;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din, r_r0_rdata, r_r1_rdata;
    logic              r_r0_rvalid, r_r1_rvalid;
    logic              w_arb, w_win, w_gnt_vld, w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    sram_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_r0_req (r0_req),
        .i_r1_req (r1_req),
        .i_arb    (w_arb),
        .o_win_id (w_win),
        .o_gnt_vld(w_gnt_vld)
    );

    assign r0_gnt       = w_gnt_vld && (w_win == REQ0);
    assign r1_gnt       = w_gnt_vld && (w_win == REQ1);
    assign w_sel_we     = (w_win == REQ1) ? r1_we    : r0_we;
    assign w_sel_addr   = (w_win == REQ1) ? r1_addr  : r0_addr;
    assign w_sel_wdata  = (w_win == REQ1) ? r1_wdata : r0_wdata;

    assign csb_n        = r_csb_n;
    assign we_n         = r_we_n;
    assign addr         = r_addr;
    assign sram_data_in = r_din;
    assign r0_rdata     = r_r0_rdata;
    assign r1_rdata     = r_r1_rdata;
    assign r0_rvalid    = r_r0_rvalid;
    assign r1_rvalid    = r_r1_rvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        w_arb = 1'b0;
        case (r_state)
            IDLE: begin
                w_arb = 1'b1;
                if (w_gnt_vld)
                    w_nxt = ISSUE;
            end
            ISSUE:   w_nxt = r_we ? IDLE : CAPTURE;
            CAPTURE: w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // Pins are loaded on the grant edge so the macro sees them during ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_id        <= REQ0;
            r_csb_n     <= 1'b1;
            r_we_n      <= 1'b1;
            r_addr      <= '0;
            r_din       <= '0;
            r_r0_rdata  <= '0;
            r_r1_rdata  <= '0;
            r_r0_rvalid <= 1'b0;
            r_r1_rvalid <= 1'b0;
        end else begin
            r_r0_rvalid <= 1'b0;
            r_r1_rvalid <= 1'b0;
            case (r_state)
                IDLE: if (w_gnt_vld) begin
                    r_we    <= w_sel_we;
                    r_id    <= w_win;
                    r_csb_n <= 1'b0;
                    r_we_n  <= !w_sel_we;
                    r_addr  <= w_sel_addr;
                    r_din   <= w_sel_wdata;
                end
                ISSUE: begin
                    r_csb_n <= 1'b1;
                    r_we_n  <= 1'b1;
                end
                CAPTURE: begin
                    if (r_id == REQ1) begin
                        r_r1_rdata  <= sram_data_out;
                        r_r1_rvalid <= 1'b1;
                    end else begin
                        r_r0_rdata  <= sram_data_out;
                        r_r0_rvalid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural 32x32 SRAM and
// per-requester read-data scoreboards.
module tb_sram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_req = 1'b0, r0_we = 1'b0;
    logic [4:0]  r0_addr = '0;
    logic [31:0] r0_wdata = '0;
    logic        r0_gnt, r0_rvalid;
    logic [31:0] r0_rdata;
    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [4:0]  r1_addr = '0;
    logic [31:0] r1_wdata = '0;
    logic        r1_gnt, r1_rvalid;
    logic [31:0] r1_rdata;
    logic        csb_n, we_n;
    logic [4:0]  addr;
    logic [31:0] sram_data_in, sram_data_out;

    logic [31:0] mem [32];
    logic [31:0] q0[$], q1[$];
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(5), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .csb_n(csb_n), .we_n(we_n), .addr(addr),
        .sram_data_in(sram_data_in), .sram_data_out(sram_data_out)
    );

    // Single-port macro model: read data appears the cycle after the select.
    always @(posedge clk) begin
        if (!csb_n) begin
            if (!we_n) mem[addr] <= sram_data_in;
            else       sram_data_out <= mem[addr];
        end
    end

    // Scoreboard: every rvalid must match the oldest expected read on its port.
    always @(negedge clk) begin
        if (rst_n && r0_rvalid) begin
            n_chk++;
            if (q0.size() == 0)
                $display("FAIL r0_unexpected_rvalid: got rdata=%h, required no rvalid", r0_rdata);
            else begin
                logic [31:0] e;
                e = q0.pop_front();
                if (r0_rdata !== e) $display("FAIL r0_rdata: got %h, required %h", r0_rdata, e);
                else n_pass++;
            end
        end
        if (rst_n && r1_rvalid) begin
            n_chk++;
            if (q1.size() == 0)
                $display("FAIL r1_unexpected_rvalid: got rdata=%h, required no rvalid", r1_rdata);
            else begin
                logic [31:0] e;
                e = q1.pop_front();
                if (r1_rdata !== e) $display("FAIL r1_rdata: got %h, required %h", r1_rdata, e);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if ({csb_n, we_n, addr, sram_data_in} !== {1'b1, 1'b1, 5'd0, 32'd0})
            $display("FAIL reset_pins: got csb_n=%b we_n=%b addr=%h din=%h, required 1 1 00 00000000",
                     csb_n, we_n, addr, sram_data_in);
        else n_pass++;
        n_chk++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata} !== '0)
            $display("FAIL reset_outputs: got gnt=%b%b rvalid=%b%b rdata0=%h rdata1=%h, required all 0",
                     r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata);
        else n_pass++;
    endtask

    task automatic test_r0_write_read();
        tick();
        r0_req = 1; r0_we = 1; r0_addr = 5'h03; r0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_chk++;
        if ({r0_gnt, r1_gnt} !== 2'b10) $display("FAIL r0_wr_gnt: got %b%b, required 10", r0_gnt, r1_gnt);
        else n_pass++;
        tick(); r0_req = 0;
        @(negedge clk);
        n_chk++;
        if ({csb_n, we_n, addr, sram_data_in} !== {1'b0, 1'b0, 5'h03, 32'hDEADBEEF})
            $display("FAIL r0_wr_pins: got csb_n=%b we_n=%b addr=%h din=%h, required 0 0 03 deadbeef",
                     csb_n, we_n, addr, sram_data_in);
        else n_pass++;
        tick();
        r0_req = 1; r0_we = 0; r0_addr = 5'h03;
        q0.push_back(32'hDEADBEEF);
        @(negedge clk);
        n_chk++;
        if (r0_gnt !== 1'b1) $display("FAIL r0_rd_gnt_t2: got %b, required 1", r0_gnt);
        else n_pass++;
        tick(); r0_req = 0;
        @(negedge clk);
        n_chk++;
        if ({csb_n, we_n} !== 2'b01) $display("FAIL r0_rd_pins: got csb_n=%b we_n=%b, required 0 1", csb_n, we_n);
        else n_pass++;
        tick(); @(negedge clk);
        n_chk++;
        if (r0_rvalid !== 1'b0) $display("FAIL r0_rvalid_early: got %b, required 0", r0_rvalid);
        else n_pass++;
        tick(); @(negedge clk);
        n_chk++;
        if (r0_rvalid !== 1'b1) $display("FAIL r0_rvalid_t3: got %b, required 1", r0_rvalid);
        else n_pass++;
        tick(); @(negedge clk);
        n_chk++;
        if (r0_rvalid !== 1'b0) $display("FAIL r0_rvalid_pulse: got %b, required 0", r0_rvalid);
        else n_pass++;
    endtask

    task automatic test_both_reads();
        int waited;
        mem[5] = 32'h1111_5555;
        mem[6] = 32'h2222_6666;
        tick();
        r0_req = 1; r0_we = 0; r0_addr = 5'h05;
        r1_req = 1; r1_we = 0; r1_addr = 5'h06;
        q0.push_back(32'h1111_5555);
        q1.push_back(32'h2222_6666);
        @(negedge clk);
        n_chk++;
        if ({r0_gnt, r1_gnt} !== 2'b10) $display("FAIL both_first_gnt: got %b%b, required 10", r0_gnt, r1_gnt);
        else n_pass++;
        tick(); r0_req = 0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_chk++;
            if (r1_gnt !== 1'b0) $display("FAIL both_r1_gnt_busy: cycle %0d got %b, required 0", c, r1_gnt);
            else n_pass++;
            tick();
        end
        @(negedge clk);
        n_chk++;
        if ({r0_rvalid, r1_gnt, r1_rvalid} !== 3'b110)
            $display("FAIL both_r1_gnt_at_rvalid: got r0_rvalid=%b r1_gnt=%b r1_rvalid=%b, required 1 1 0",
                     r0_rvalid, r1_gnt, r1_rvalid);
        else n_pass++;
        tick(); r1_req = 0;
        waited = 0;
        while (!(r1_rvalid === 1'b1) && waited < 10) begin
            @(negedge clk);
            if (r1_rvalid !== 1'b1) begin waited++; tick(); end
        end
        n_chk++;
        if (waited != 2) $display("FAIL both_r1_latency: got %0d cycles after gnt+1, required 2", waited);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int ids[10];
        int exp_ids[10];
        int n = 0, cyc = 0, last = 0;
`ifdef SRAM_ARB_RR_EN
        exp_ids = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_ids = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
        tick(); rst_n = 0; #3; rst_n = 1;
        tick();
        r0_req = 1; r0_we = 1; r0_addr = 5'h08; r0_wdata = $urandom;
        r1_req = 1; r1_we = 1; r1_addr = 5'h09; r1_wdata = $urandom;
        while (n < 10 && cyc < 60) begin
            @(negedge clk);
            if (r0_gnt === 1'b1 && r1_gnt === 1'b1) begin
                n_chk++;
                $display("FAIL b2b_dual_gnt: got both gnt, required one");
            end else if (r0_gnt === 1'b1 || r1_gnt === 1'b1) begin
                ids[n] = (r1_gnt === 1'b1) ? 1 : 0;
                if (n > 0) begin
                    n_chk++;
                    if (cyc - last != 2) $display("FAIL b2b_gap: grant %0d got gap %0d, required 2", n, cyc - last);
                    else n_pass++;
                end
                last = cyc;
                n++;
            end
            tick();
            r0_wdata = $urandom; r1_wdata = $urandom;
            cyc++;
        end
        r0_req = 0; r1_req = 0;
        n_chk++;
        if (n != 10) $display("FAIL b2b_timeout: got %0d grants, required 10", n);
        else n_pass++;
        for (int i = 0; i < n; i++) begin
            n_chk++;
            if (ids[i] != exp_ids[i]) $display("FAIL b2b_order: grant %0d got r%0d, required r%0d", i, ids[i], exp_ids[i]);
            else n_pass++;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int waited;
        tick();
        r0_req = 1; r0_we = 0; r0_addr = 5'h05;
        @(negedge clk);
        n_chk++;
        if (r0_gnt !== 1'b1) $display("FAIL rstmid_gnt: got %b, required 1", r0_gnt);
        else n_pass++;
        tick(); r0_req = 0;
        rst_n = 0; #1;
        n_chk++;
        if ({csb_n, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid} !== 5'b10000)
            $display("FAIL rstmid_abort: got csb_n=%b gnt=%b%b rvalid=%b%b, required 1 00 00",
                     csb_n, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid);
        else n_pass++;
        @(negedge clk); rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_chk++;
            if ({r0_rvalid, r1_rvalid} !== 2'b00) $display("FAIL rstmid_rvalid: cycle %0d got %b%b, required 00", c, r0_rvalid, r1_rvalid);
            else n_pass++;
        end
        tick();
        r0_req = 1; r0_we = 0; r0_addr = 5'h06;
        q0.push_back(32'h2222_6666);
        @(negedge clk);
        n_chk++;
        if (r0_gnt !== 1'b1) $display("FAIL rstmid_post_gnt: got %b, required 1", r0_gnt);
        else n_pass++;
        tick(); r0_req = 0;
        waited = 0;
        while (!(r0_rvalid === 1'b1) && waited < 10) begin
            @(negedge clk);
            if (r0_rvalid !== 1'b1) begin waited++; tick(); end
        end
        n_chk++;
        if (waited != 2) $display("FAIL rstmid_post_latency: got %0d, required 2", waited);
        else n_pass++;
        tick();
    endtask

    task automatic test_r1_alone();
        int waited;
        tick();
        r1_req = 1; r1_we = 1; r1_addr = 5'h1F; r1_wdata = 32'h0000_00A5;
        @(negedge clk);
        n_chk++;
        if ({r0_gnt, r1_gnt} !== 2'b01) $display("FAIL r1_wr_gnt: got %b%b, required 01", r0_gnt, r1_gnt);
        else n_pass++;
        tick(); r1_req = 0;
        @(negedge clk);
        n_chk++;
        if ({csb_n, we_n, addr, sram_data_in} !== {1'b0, 1'b0, 5'h1F, 32'h0000_00A5})
            $display("FAIL r1_wr_pins: got csb_n=%b we_n=%b addr=%h din=%h, required 0 0 1f 000000a5",
                     csb_n, we_n, addr, sram_data_in);
        else n_pass++;
        tick();
        r1_req = 1; r1_we = 0; r1_addr = 5'h1F;
        q1.push_back(32'h0000_00A5);
        @(negedge clk);
        n_chk++;
        if (r1_gnt !== 1'b1) $display("FAIL r1_rd_gnt: got %b, required 1", r1_gnt);
        else n_pass++;
        tick(); r1_req = 0;
        @(negedge clk);
        n_chk++;
        if ({csb_n, we_n, addr} !== {1'b0, 1'b1, 5'h1F})
            $display("FAIL r1_rd_pins: got csb_n=%b we_n=%b addr=%h, required 0 1 1f", csb_n, we_n, addr);
        else n_pass++;
        tick();
        waited = 0;
        while (!(r1_rvalid === 1'b1) && waited < 10) begin
            @(negedge clk);
            n_chk++;
            if (r0_rvalid !== 1'b0) $display("FAIL r1_alone_r0_rvalid: got %b, required 0", r0_rvalid);
            else n_pass++;
            if (r1_rvalid !== 1'b1) begin waited++; tick(); end
        end
        n_chk++;
        if (waited != 1) $display("FAIL r1_rd_latency: got %0d, required 1", waited);
        else n_pass++;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        sram_data_out = '0;
        #12 rst_n = 1;
        test_reset();
        test_r0_write_read();
        test_both_reads();
        test_back_to_back();
        test_reset_mid();
        test_r1_alone();
        repeat (4) tick();
        n_chk++;
        if (q0.size() + q1.size() != 0)
            $display("FAIL scoreboard_drain: got %0d/%0d pending reads, required 0/0", q0.size(), q1.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
